// File: rtl/ber_checker_pkg.sv
// Shared definitions for the BER checker and its PRBS9 reference generator.
// Contents: PRBS9 order/tap positions, default generator seed, FSM encoding.
package ber_checker_pkg;

    // x^9 + x^5 + 1, Fibonacci form: feedback = state[8] ^ state[4]
    localparam int             PRBS_ORDER    = 9;
    localparam int             PRBS_TAP_A    = 8;
    localparam int             PRBS_TAP_B    = 4;
    localparam logic [8:0]     PRBS_SEED_DEF = 9'h1AA;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } ber_state_t;

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 generator (x^9+x^5+1, Fibonacci). Advances one bit per enabled cycle.
// Ports:
//   clk      - clock
//   i_reset  - asynchronous reset, active-low (loads SEED)
//   i_en     - advance strobe
//   o_bit    - current output bit (state MSB)
module prbs9_gen
    import ber_checker_pkg::*;
#(
    parameter logic [PRBS_ORDER-1:0] SEED = PRBS_SEED_DEF
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_bit
);

    logic [PRBS_ORDER-1:0] r_state;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            r_state <= SEED;
        else if (i_en)
            r_state <= {r_state[PRBS_ORDER-2:0], r_state[PRBS_TAP_A] ^ r_state[PRBS_TAP_B]};
    end

    assign o_bit = r_state[PRBS_ORDER-1];

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker for one sliced symbol rail. Hard bit = symbol sign,
// compared against a delayed PRBS9 reference. Sweeps the delay until a clean
// window is seen, then accumulates bit/error counts while locked.
// Ports:
//   clk          - clock
//   i_reset      - asynchronous reset, active-low
//   i_en         - symbol strobe (one symbol per asserted cycle)
//   i_data       - signed sliced symbol, only the MSB is used
//   i_clear      - synchronous clear of the accumulators
//   o_locked     - 1 while locked
//   o_delay      - candidate / locked reference delay
//   o_bit_count  - bits compared while locked (saturating)
//   o_err_count  - bit errors while locked (saturating)
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int             NBT_IN    = 12,
    parameter int             SEQ_LEN   = 511,
    parameter int             NB_DLY    = 9,
    parameter logic [8:0]     PRBS_SEED = PRBS_SEED_DEF,
    parameter int             WIN_LEN   = 511,
    parameter int             NB_WIN    = 9,
    parameter int             LOCK_THR  = 0,
    parameter int             LOSS_THR  = 64,
    parameter int             NB_CNT    = 64
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [NBT_IN-1:0] i_data,
    input  logic              i_clear,
    output logic              o_locked,
    output logic [NB_DLY-1:0] o_delay,
    output logic [NB_CNT-1:0] o_bit_count,
    output logic [NB_CNT-1:0] o_err_count
);

    logic                w_prbs_bit;
    logic                w_rx;
    logic                w_ref;
    logic                w_err;
    logic                w_win_end;
    logic                w_lock_ok;
    logic                w_loss;
    logic                w_unused;
    logic [NB_WIN:0]     w_win_tot;   // one extra bit: a full window of errors
    logic [NB_DLY-1:0]   w_next_dly;

    logic [SEQ_LEN-1:0]  r_hist;
    logic [NB_WIN-1:0]   r_win_cnt;
    logic [NB_WIN:0]     r_win_err;
    logic [NB_DLY-1:0]   r_delay;
    ber_state_t          r_state;
    logic                r_locked;
    logic [NB_CNT-1:0]   r_bit_cnt;
    logic [NB_CNT-1:0]   r_err_cnt;

    prbs9_gen #(.SEED(PRBS_SEED)) u_prbs (
        .clk     (clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .o_bit   (w_prbs_bit)
    );

    assign w_rx       = i_data[NBT_IN-1];
    assign w_unused   = ^i_data[NBT_IN-2:0];
    // Reference tap uses the history before this cycle's push.
    assign w_ref      = r_hist[r_delay];
    assign w_err      = w_rx ^ w_ref;
    assign w_win_end  = (r_win_cnt == NB_WIN'(WIN_LEN - 1));
    assign w_win_tot  = r_win_err + (NB_WIN + 1)'(w_err);
    assign w_lock_ok  = (int'(w_win_tot) <= LOCK_THR);
    assign w_loss     = (int'(w_win_tot) >  LOSS_THR);
    assign w_next_dly = (r_delay == NB_DLY'(SEQ_LEN - 1)) ? '0 : r_delay + NB_DLY'(1);

    // Reference history, hist[0] newest.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            r_hist <= '0;
        else if (i_en)
            r_hist <= {r_hist[SEQ_LEN-2:0], w_prbs_bit};
    end

    // Evaluation window; the closing cycle's error is part of w_win_tot.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_en) begin
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + NB_WIN'(1);
                r_win_err <= w_win_tot;
            end
        end
    end

    // Search / lock FSM with registered outputs.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_delay  <= '0;
        end else if (i_en && w_win_end) begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_lock_ok) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end else begin
                        r_delay  <= w_next_dly;
                    end
                end
                ST_LOCKED: begin
                    if (w_loss) begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                        r_delay  <= w_next_dly;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Saturating accumulators; clear wins over any increment.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_en && (r_state == ST_LOCKED)) begin
            if (r_bit_cnt != '1)
                r_bit_cnt <= r_bit_cnt + NB_CNT'(1);
            if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + NB_CNT'(1);
        end
    end

    assign o_locked    = r_locked;
    assign o_delay     = r_delay;
    assign o_bit_count = r_bit_cnt;
    assign o_err_count = r_err_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker with a short window and narrow accumulators so that
// full delay sweeps and saturation fit in a short run. A behavioural model
// (PRBS table indexed by symbol number) predicts every output each cycle.
module tb_ber_checker;

    localparam int     NBT   = 12;
    localparam int     SEQ   = 511;
    localparam int     WIN   = 32;
    localparam int     LOCKT = 0;
    localparam int     LOSST = 8;
    localparam int     NCNT  = 10;
    localparam longint CMAX  = (64'd1 << NCNT) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            clr;
    logic [NBT-1:0]  data;
    logic            locked;
    logic [8:0]      dly;
    logic [NCNT-1:0] bc;
    logic [NCNT-1:0] ec;

    always #5 clk = ~clk;

    ber_checker #(
        .NBT_IN(NBT), .SEQ_LEN(SEQ), .NB_DLY(9), .PRBS_SEED(9'h1AA),
        .WIN_LEN(WIN), .NB_WIN(5), .LOCK_THR(LOCKT), .LOSS_THR(LOSST), .NB_CNT(NCNT)
    ) dut (
        .clk(clk), .i_reset(rst_n), .i_en(en), .i_data(data), .i_clear(clr),
        .o_locked(locked), .o_delay(dly), .o_bit_count(bc), .o_err_count(ec)
    );

    bit     p [SEQ];
    int     total = 0;
    int     bad   = 0;

    // model state
    int     n;
    bit     m_lock;
    int     m_dly, m_wcnt, m_werr;
    longint m_bits, m_errs;

    // source settings: rx[n] = p[n-1-s_dly] ^ s_inv ^ flip
    int     s_dly;
    bit     s_inv;

    typedef struct {
        int dly;
        bit inv;
        int per;
        int n_en;
        bit e_lock;
        int e_dly;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit pbit(input int i);
        return (i < 0) ? 1'b0 : p[i % SEQ];
    endfunction

    task automatic model_reset();
        n = 0; m_lock = 0; m_dly = 0; m_wcnt = 0; m_werr = 0; m_bits = 0; m_errs = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_locked"}, locked, m_lock);
        chk({tag, "_delay"},  dly,    m_dly);
        chk({tag, "_bits"},   bc,     m_bits);
        chk({tag, "_errs"},   ec,     m_errs);
    endtask

    // Called at posedge+1; returns at the next posedge+1 after checking.
    task automatic step(input bit e, input bit c, input bit flip);
        bit rx, rb, err;
        int tot;
        rx   = pbit(n - 1 - s_dly) ^ s_inv ^ flip;
        en   = e;
        clr  = c;
        data = {rx, 11'($urandom)};
        @(posedge clk);
        if (c) begin m_bits = 0; m_errs = 0; end
        if (e) begin
            rb  = pbit(n - 1 - m_dly);
            err = rx ^ rb;
            if (m_lock && !c) begin
                if (m_bits < CMAX) m_bits++;
                if (err && m_errs < CMAX) m_errs++;
            end
            tot = m_werr + int'(err);
            if (m_wcnt == WIN - 1) begin
                m_wcnt = 0; m_werr = 0;
                if (!m_lock) begin
                    if (tot <= LOCKT) m_lock = 1;
                    else m_dly = (m_dly + 1) % SEQ;
                end else if (tot > LOSST) begin
                    m_lock = 0; m_dly = (m_dly + 1) % SEQ;
                end
            end else begin
                m_wcnt++; m_werr = tot;
            end
            n++;
        end
        #1;
        chk_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst");
        rst_n = 1;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_rst(input string tag);
        #3 rst_n = 0;
        #1;
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_delay"},  dly,    0);
        chk({tag, "_bits"},   bc,     0);
        chk({tag, "_errs"},   ec,     0);
        model_reset();
        en = 0; clr = 0;
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        logic [8:0] s;
        s = 9'h1AA;
        for (int i = 0; i < SEQ; i++) begin
            p[i] = s[8];
            s = {s[7:0], s[8] ^ s[4]};
        end
        en = 0; clr = 0; data = '0; rst_n = 0; s_dly = 0; s_inv = 0;

        tbl[0] = '{dly: 37,  inv: 0, per: 4, n_en: 38*WIN,     e_lock: 1, e_dly: 37};
        tbl[1] = '{dly: 37,  inv: 0, per: 1, n_en: 38*WIN - 1, e_lock: 0, e_dly: 37};
        tbl[2] = '{dly: 5,   inv: 0, per: 3, n_en: 6*WIN,      e_lock: 1, e_dly: 5};
        tbl[3] = '{dly: 0,   inv: 0, per: 1, n_en: WIN,        e_lock: 1, e_dly: 0};
        tbl[4] = '{dly: 0,   inv: 1, per: 1, n_en: 510*WIN,    e_lock: 0, e_dly: 510};
        tbl[5] = '{dly: 0,   inv: 1, per: 1, n_en: 511*WIN,    e_lock: 0, e_dly: 0};
        tbl[6] = '{dly: 100, inv: 1, per: 1, n_en: 40*WIN,     e_lock: 0, e_dly: 40};
        tbl[7] = '{dly: 12,  inv: 0, per: 2, n_en: 13*WIN,     e_lock: 1, e_dly: 12};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            s_dly = tbl[i].dly;
            s_inv = tbl[i].inv;
            for (int k = 0; k < tbl[i].n_en; k++) begin
                repeat (tbl[i].per - 1) step(0, 0, 0);
                step(1, 0, 0);
            end
            chk($sformatf("vec%0d_lock", i),  locked, tbl[i].e_lock);
            chk($sformatf("vec%0d_delay", i), dly,    tbl[i].e_dly);
        end

        // Lock, then sparse errors: 1000 bits with every 100th flipped.
        do_reset();
        s_dly = 37; s_inv = 0;
        repeat (38*WIN) step(1, 0, 0);
        chk("a_locked", locked, 1);
        for (int k = 0; k < 1000; k++) step(1, 0, (k % 100) == 99);
        chk("a_bits",  bc, 1000);
        chk("a_errs",  ec, 10);
        chk("a_held",  locked, 1);

        // Source delay moves: lock is lost, search resumes, relocks at 42.
        s_dly = 42;
        repeat (12*WIN) step(1, 0, 0);
        chk("b_relock", locked, 1);
        chk("b_delay",  dly,    42);
        chk("b_grew",   (ec > 10), 1);

        // 8 errors per window keeps lock and drives both counts to saturation.
        for (int k = 0; k < 4500; k++) step(1, 0, (k % 4) == 3);
        chk("c_sat_bits", bc, CMAX);
        chk("c_sat_errs", ec, CMAX);
        chk("c_lock",     locked, 1);
        // clear lands on an erroring enabled cycle
        for (int k = 4500; k < 4504; k++) step(1, k == 4503, (k % 4) == 3);
        chk("c_clr_bits", bc, 0);
        chk("c_clr_errs", ec, 0);
        repeat (5) step(1, 0, 0);
        step(0, 1, 0);
        chk("c_clr_idle", bc, 0);
        repeat (3) step(1, 0, 0);
        async_rst("c_arst");
        repeat (3) step(1, 0, 0);

        // Randomized enables, clears, bit errors and a mid-run delay change.
        do_reset();
        s_dly = $urandom_range(0, 40);
        for (int k = 0; k < 6000; k++) begin
            if (k == 3000) s_dly = $urandom_range(0, 60);
            step(($urandom % 4) != 0, ($urandom % 300) == 0, ($urandom % 48) == 0);
        end

        // Reset mid-search at delay 20, then search restarts from 0.
        do_reset();
        s_dly = 0; s_inv = 1;
        repeat (20*WIN + 5) step(1, 0, 0);
        chk("d_delay20", dly, 20);
        async_rst("d_arst");
        repeat (5) step(1, 0, 0);
        chk("d_restart", dly, 0);
        repeat (WIN) step(1, 0, 0);
        chk("d_next", dly, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
